mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the MIPS pipeline, between the EX/MEM buffer and the MEM/WB buffer (`buffer4`). Non-memory instructions pass through with zero latency. Loads and stores are issued to a variable-latency data memory over a req/ack handshake, and the upstream buffer is stalled until the access completes. Results are presented as alu/mem/dest/op/signals fields, with bubbles driven while stalled.

## Interface
- No parameters; data and address are fixed at 32 bits.

- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `valid_in` in 1: EX/MEM holds a live instruction.
- `alu_in` in 32: ALU result, which is the effective address for memory ops.
- `store_in` in 32: rt value used as store data.
- `dest_in` in 5, `op_in` in 6, `signals_in` in 8: instruction fields from EX/MEM.
- `stall_out` out 1: when high, EX/MEM must hold its contents (its load = !stall_out).
- `dmem_req` out 1, `dmem_we` out 1: access request and write flag.
- `dmem_addr` out 32: word-aligned address ({addr[31:2],2'b00}).
- `dmem_be` out 4: byte enables.
- `dmem_wdata` out 32: write data.
- `dmem_rdata` in 32, `dmem_ack` in 1: read data, and completion (valid for one cycle).
- `valid_out` out 1, `alu_out` out 32, `mem_out` out 32, `dest_out` out 5, `op_out` out 6, `signals_out` out 8: outputs to the MEM/WB buffer.
- `addr_err` out 1, `bad_addr` out 32: misaligned-access flag (one-cycle pulse) and the offending address.

## Operation
- Memory ops (op): lb 0x20, lh 0x21, lw 0x23, lbu 0x24, lhu 0x25, sb 0x28, sh 0x29, sw 0x2B. Every other op is a non-memory op.
- Byte order is little-endian. Lane = addr[1:0].
  - Byte enables: sb uses 0001<<a; sh uses 0011 or 1100 selected by a[1]; sw uses 1111.
  - Write data: sb drives {4{b}}, sh drives {2{h}}, sw drives the full word.
- Load extract: select the lane from rdata.
  - lb and lh sign-extend.
  - lbu and lhu zero-extend.
  - lw takes rdata unchanged.
- Alignment: halfword ops need a[0]=0; word ops need a[1:0]=0.
- A bubble means valid_out=0 and alu_out, mem_out, dest_out, op_out, signals_out are all 0.

FSM states:
- IDLE, stall_out=0:
  - No valid_in: output a bubble.
  - Valid non-memory op: combinational pass-through. valid_out=1, alu/dest/op/signals follow the inputs, mem_out=0.
  - Valid aligned memory op: output a bubble, capture alu/store/dest/op/signals into hold registers at the clock edge, then go to WAIT.
  - Valid misaligned memory op: output a bubble and stay in IDLE. Next cycle: addr_err=1 and bad_addr=alu_in (registered). No dmem_req is issued.
- WAIT, stall_out=1:
  - Output a bubble.
  - dmem_req=1. dmem_we, dmem_addr, dmem_be, dmem_wdata are driven from the hold registers.
  - On dmem_ack: register the extended rdata (0 for stores) into the mem hold register and go to DONE. Without ack, stay in WAIT indefinitely.
- DONE, stall_out=1:
  - valid_out=1. Output the held alu/dest/op/signals and the held mem data.
  - Go to IDLE. The held upstream instruction is processed in IDLE on the following cycle.
- dmem_ack in IDLE or DONE is ignored.
- dmem_req, dmem_we, dmem_be are 0 outside WAIT.

## Timing
- Non-memory op latency: 0 cycles, no stall.
- Memory op: capture in cycle T. WAIT runs from T+1. With an ack in cycle T+1, DONE is in T+2 and the next instruction is handled in IDLE at T+3.
  - Minimum occupancy is 3 cycles.
  - Each extra cycle of memory latency adds one WAIT cycle.
- stall_out is high exactly during WAIT and DONE.
- dmem_ack may arrive in the first WAIT cycle.
- Reset asserted (low):
  - Immediately forces state to IDLE and clears the hold registers, addr_err and bad_addr.
  - dmem_req falls asynchronously.
  - stall_out=0 and all outputs are 0 (bubble).
  - An access in flight is abandoned. A late dmem_ack after reset is ignored.
- Back-to-back memory ops: the second op is accepted in the IDLE cycle after DONE.

## Structure
- Package `mips_mem_pkg`: opcode constants, FSM state enum {IDLE, WAIT, DONE}, and bubble constant.
- Sub-module `mem_align` (combinational): from op, addr[1:0], store data and rdata, produces be, wdata, the extended load data and the misaligned flag. It is instantiated once.
- Top level: FSM, hold registers, addr_err register, and output muxing.

## Test plan
- Pass-through: op=0x00, alu_in=0x1234 -> same cycle valid_out=1, alu_out=0x1234, mem_out=0, stall_out=0.
- lw at 0x100 with ack after 3 WAIT cycles, rdata=0xDEADBEEF:
  - dmem_addr=0x100, be=1111.
  - stall_out high for 4 cycles.
  - DONE shows mem_out=0xDEADBEEF.
- Sub-word loads with rdata=0x80FF7F01:
  - lb at 0x103 -> 0xFFFFFF80.
  - lbu at 0x103 -> 0x00000080.
  - lh at 0x102 -> 0xFFFF80FF.
  - lhu at 0x100 -> 0x00007F01.
- sb 0xAB at 0x202 -> dmem_we=1, be=0100, wdata=0xABABABAB, addr=0x200. DONE shows mem_out=0.
- Misaligned lw at 0x101 -> no dmem_req, bubble output, addr_err pulses next cycle with bad_addr=0x101.
- Reset pulled low during WAIT -> dmem_req=0 at once, state IDLE. A following ack is ignored and the next instruction is processed normally.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared opcodes, FSM states and result type for the MIPS memory stage
package mips_mem_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [4:0]  dest;
    logic [5:0]  op;
    logic [7:0]  signals;
  } mem_result_t;

  localparam mem_result_t BUBBLE = '0;

  function automatic logic is_store_op(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic is_load_op(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_mem_op(input logic [5:0] op);
    return is_load_op(op) || is_store_op(op);
  endfunction

endpackage

// File: rtl/mem_align.sv
// rtl/mem_align.sv - little-endian lane steering: byte enables, store replication,
// load extraction with sign/zero extension, and misalignment detection
module mem_align
  import mips_mem_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  lane,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (lane)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    be         = 4'b0000;
    wdata      = 32'h0;
    load_data  = 32'h0;
    misaligned = 1'b0;
    case (op)
      OP_LB: begin
        be        = 4'b0001 << lane;
        load_data = {{24{byte_sel[7]}}, byte_sel};
      end
      OP_LBU: begin
        be        = 4'b0001 << lane;
        load_data = {24'h0, byte_sel};
      end
      OP_LH: begin
        be         = lane[1] ? 4'b1100 : 4'b0011;
        load_data  = {{16{half_sel[15]}}, half_sel};
        misaligned = lane[0];
      end
      OP_LHU: begin
        be         = lane[1] ? 4'b1100 : 4'b0011;
        load_data  = {16'h0, half_sel};
        misaligned = lane[0];
      end
      OP_LW: begin
        be         = 4'b1111;
        load_data  = rdata;
        misaligned = (lane != 2'd0);
      end
      OP_SB: begin
        be    = 4'b0001 << lane;
        wdata = {4{store_data[7:0]}};
      end
      OP_SH: begin
        be         = lane[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{store_data[15:0]}};
        misaligned = lane[0];
      end
      OP_SW: begin
        be         = 4'b1111;
        wdata      = store_data;
        misaligned = (lane != 2'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS MEM stage: zero-latency pass-through for ALU ops,
// stalling req/ack data-memory access for loads and stores
module mem_stage
  import mips_mem_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] store_in,
  input  logic [4:0]  dest_in,
  input  logic [5:0]  op_in,
  input  logic [7:0]  signals_in,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        valid_out,
  output logic [31:0] alu_out,
  output logic [31:0] mem_out,
  output logic [4:0]  dest_out,
  output logic [5:0]  op_out,
  output logic [7:0]  signals_out,
  output logic        addr_err,
  output logic [31:0] bad_addr
);

  mem_state_t  state, state_next;

  logic [31:0] alu_h, store_h, mem_h;
  logic [4:0]  dest_h;
  logic [5:0]  op_h;
  logic [7:0]  signals_h;

  logic [5:0]  al_op;
  logic [1:0]  al_lane;
  logic [31:0] al_store;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_load;
  logic        al_misaligned;

  logic        capture, err_now, in_wait;
  mem_result_t res;

  // In IDLE the aligner judges the incoming op; otherwise it serves the held access.
  always_comb begin
    al_op    = (state == IDLE) ? op_in         : op_h;
    al_lane  = (state == IDLE) ? alu_in[1:0]   : alu_h[1:0];
    al_store = (state == IDLE) ? store_in      : store_h;
  end

  mem_align u_align (
    .op         (al_op),
    .lane       (al_lane),
    .store_data (al_store),
    .rdata      (dmem_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_data  (al_load),
    .misaligned (al_misaligned)
  );

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    err_now    = 1'b0;
    res        = BUBBLE;
    case (state)
      IDLE: begin
        if (valid_in) begin
          if (!is_mem_op(op_in)) begin
            res.valid   = 1'b1;
            res.alu     = alu_in;
            res.dest    = dest_in;
            res.op      = op_in;
            res.signals = signals_in;
          end else if (al_misaligned) begin
            err_now = 1'b1;
          end else begin
            capture    = 1'b1;
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (dmem_ack) state_next = DONE;
      end
      DONE: begin
        res.valid   = 1'b1;
        res.alu     = alu_h;
        res.mem     = mem_h;
        res.dest    = dest_h;
        res.op      = op_h;
        res.signals = signals_h;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Keep the MEM/WB side quiet while reset is held, even for pass-through ops.
    if (!reset) res = BUBBLE;
  end

  always_comb begin
    in_wait    = (state == WAIT);
    stall_out  = (state != IDLE);
    dmem_req   = in_wait;
    dmem_we    = in_wait && is_store_op(op_h);
    dmem_addr  = in_wait ? {alu_h[31:2], 2'b00} : 32'h0;
    dmem_be    = in_wait ? al_be : 4'b0000;
    dmem_wdata = in_wait ? al_wdata : 32'h0;
  end

  always_comb begin
    valid_out   = res.valid;
    alu_out     = res.alu;
    mem_out     = res.mem;
    dest_out    = res.dest;
    op_out      = res.op;
    signals_out = res.signals;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      alu_h     <= 32'h0;
      store_h   <= 32'h0;
      mem_h     <= 32'h0;
      dest_h    <= 5'h0;
      op_h      <= 6'h0;
      signals_h <= 8'h0;
      addr_err  <= 1'b0;
      bad_addr  <= 32'h0;
    end else begin
      state    <= state_next;
      addr_err <= err_now;
      if (err_now) bad_addr <= alu_in;
      if (capture) begin
        alu_h     <= alu_in;
        store_h   <= store_in;
        dest_h    <= dest_in;
        op_h      <= op_in;
        signals_h <= signals_in;
      end
      // Stores complete with zero load data.
      if (in_wait && dmem_ack) mem_h <= al_load;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage: vector table plus
// scoreboard of expected MEM/WB results, and hand-written corner sequences
module tb_mem_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [31:0] alu_in, store_in;
  logic [4:0]  dest_in;
  logic [5:0]  op_in;
  logic [7:0]  signals_in;
  logic        stall_out, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic        valid_out;
  logic [31:0] alu_out, mem_out;
  logic [4:0]  dest_out;
  logic [5:0]  op_out;
  logic [7:0]  signals_out;
  logic        addr_err;
  logic [31:0] bad_addr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] mem;
    logic [4:0]  dest;
    logic [5:0]  op;
    logic [7:0]  sig;
  } exp_t;

  exp_t sb_q[$];

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] store;
    logic [31:0] rdata;
    int          waits;
    logic [31:0] exp_mem;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic        exp_we;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[$];

  mem_stage dut (
    .clock       (clock),
    .reset       (reset),
    .valid_in    (valid_in),
    .alu_in      (alu_in),
    .store_in    (store_in),
    .dest_in     (dest_in),
    .op_in       (op_in),
    .signals_in  (signals_in),
    .stall_out   (stall_out),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_be     (dmem_be),
    .dmem_wdata  (dmem_wdata),
    .dmem_rdata  (dmem_rdata),
    .dmem_ack    (dmem_ack),
    .valid_out   (valid_out),
    .alu_out     (alu_out),
    .mem_out     (mem_out),
    .dest_out    (dest_out),
    .op_out      (op_out),
    .signals_out (signals_out),
    .addr_err    (addr_err),
    .bad_addr    (bad_addr)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every valid result leaving the stage must match the oldest expectation.
  always @(negedge clock) begin
    if (reset === 1'b1 && valid_out === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_valid_out", 32'(valid_out), 32'h0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_alu", alu_out, e.alu);
        chk("sb_mem", mem_out, e.mem);
        chk("sb_dest", 32'(dest_out), 32'(e.dest));
        chk("sb_op", 32'(op_out), 32'(e.op));
        chk("sb_sig", 32'(signals_out), 32'(e.sig));
      end
    end
  end

  task automatic push_exp(input logic [31:0] alu, input logic [31:0] mem,
                          input logic [4:0] dest, input logic [5:0] op, input logic [7:0] sig);
    exp_t e;
    e.alu = alu; e.mem = mem; e.dest = dest; e.op = op; e.sig = sig;
    sb_q.push_back(e);
  endtask

  // Starts and ends one time unit after a rising edge, with the stage in IDLE.
  task automatic apply(input vec_t v, input int idx);
    int  n;
    bit  broke;
    logic [4:0] d;
    logic [7:0] s;
    d = 5'(idx + 1);
    s = 8'(8'h40 + idx);
    push_exp(v.addr, v.exp_mem, d, v.op, s);
    valid_in = 1'b1; op_in = v.op; alu_in = v.addr; store_in = v.store;
    dest_in = d; signals_in = s;
    @(negedge clock);
    chk({v.name, "/stall_accept"}, 32'(stall_out), 32'h0);
    if (v.waits == 0) begin
      chk({v.name, "/passthru_valid"}, 32'(valid_out), 32'h1);
      @(posedge clock); #1;
      valid_in = 1'b0;
      return;
    end
    chk({v.name, "/accept_bubble"}, 32'(valid_out), 32'h0);
    @(posedge clock); #1;
    valid_in = 1'b0;
    dmem_rdata = v.rdata;
    n = 0;
    broke = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      dmem_ack = (c == v.waits);
      @(negedge clock);
      if (c == 1) begin
        chk({v.name, "/req"}, 32'(dmem_req), 32'h1);
        chk({v.name, "/addr"}, dmem_addr, v.exp_addr);
        chk({v.name, "/be"}, 32'(dmem_be), 32'(v.exp_be));
        chk({v.name, "/we"}, 32'(dmem_we), 32'(v.exp_we));
        if (v.exp_we) chk({v.name, "/wdata"}, dmem_wdata, v.exp_wdata);
      end
      if (stall_out !== 1'b1) begin
        broke = 1'b1;
        break;
      end
      n++;
      @(posedge clock); #1;
    end
    dmem_ack = 1'b0;
    chk({v.name, "/stall_cycles"}, 32'(n), 32'(v.waits + 1));
    if (broke) begin
      @(posedge clock); #1;
    end
  endtask

  function automatic vec_t mk(input string name, input logic [5:0] op, input logic [31:0] addr,
                              input logic [31:0] store, input logic [31:0] rdata, input int waits,
                              input logic [31:0] exp_mem, input logic [31:0] exp_addr,
                              input logic [3:0] exp_be, input logic exp_we,
                              input logic [31:0] exp_wdata);
    vec_t v;
    v.name = name; v.op = op; v.addr = addr; v.store = store; v.rdata = rdata;
    v.waits = waits; v.exp_mem = exp_mem; v.exp_addr = exp_addr; v.exp_be = exp_be;
    v.exp_we = exp_we; v.exp_wdata = exp_wdata;
    return v;
  endfunction

  initial begin
    reset = 1'b0; valid_in = 1'b0; alu_in = '0; store_in = '0; dest_in = '0;
    op_in = '0; signals_in = '0; dmem_rdata = '0; dmem_ack = 1'b0;

    // waits==0 marks a pass-through op; otherwise the ack comes on the last WAIT cycle.
    vecs.push_back(mk("passthru",  6'h00, 32'h0000_1234, 32'h0, 32'h0, 0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0));
    vecs.push_back(mk("lw_100",    6'h23, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 3, 32'hDEAD_BEEF, 32'h100, 4'b1111, 1'b0, 32'h0));
    vecs.push_back(mk("lb_103",    6'h20, 32'h0000_0103, 32'h0, 32'h80FF_7F01, 1, 32'hFFFF_FF80, 32'h100, 4'b1000, 1'b0, 32'h0));
    vecs.push_back(mk("lbu_103",   6'h24, 32'h0000_0103, 32'h0, 32'h80FF_7F01, 2, 32'h0000_0080, 32'h100, 4'b1000, 1'b0, 32'h0));
    vecs.push_back(mk("lh_102",    6'h21, 32'h0000_0102, 32'h0, 32'h80FF_7F01, 1, 32'hFFFF_80FF, 32'h100, 4'b1100, 1'b0, 32'h0));
    vecs.push_back(mk("lhu_100",   6'h25, 32'h0000_0100, 32'h0, 32'h80FF_7F01, 1, 32'h0000_7F01, 32'h100, 4'b0011, 1'b0, 32'h0));
    vecs.push_back(mk("sb_202",    6'h28, 32'h0000_0202, 32'h0000_00AB, 32'h5555_5555, 2, 32'h0, 32'h200, 4'b0100, 1'b1, 32'hABAB_ABAB));
    vecs.push_back(mk("sh_106",    6'h29, 32'h0000_0106, 32'h0000_1234, 32'h0, 1, 32'h0, 32'h104, 4'b1100, 1'b1, 32'h1234_1234));
    vecs.push_back(mk("sw_108",    6'h2B, 32'h0000_0108, 32'hCAFE_F00D, 32'h0, 1, 32'h0, 32'h108, 4'b1111, 1'b1, 32'hCAFE_F00D));
    vecs.push_back(mk("passthru2", 6'h0F, 32'h8000_0001, 32'h0, 32'h0, 0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0));

    // Reset state: even a live pass-through op must not escape while reset is low.
    valid_in = 1'b1; op_in = 6'h00; alu_in = 32'h77; dest_in = 5'd9; signals_in = 8'hFF;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_stall", 32'(stall_out), 32'h0);
    chk("rst_req", 32'(dmem_req), 32'h0);
    chk("rst_valid_out", 32'(valid_out), 32'h0);
    chk("rst_alu_out", alu_out, 32'h0);
    chk("rst_addr_err", 32'(addr_err), 32'h0);
    chk("rst_bad_addr", bad_addr, 32'h0);
    valid_in = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Misaligned lw: bubble, no request, one-cycle addr_err pulse next cycle.
    valid_in = 1'b1; op_in = 6'h23; alu_in = 32'h0000_0101; dest_in = 5'd20; signals_in = 8'h3C;
    @(negedge clock);
    chk("mis_valid_out", 32'(valid_out), 32'h0);
    chk("mis_req", 32'(dmem_req), 32'h0);
    chk("mis_stall", 32'(stall_out), 32'h0);
    chk("mis_err_early", 32'(addr_err), 32'h0);
    @(posedge clock); #1;
    valid_in = 1'b0;
    @(negedge clock);
    chk("mis_err", 32'(addr_err), 32'h1);
    chk("mis_bad_addr", bad_addr, 32'h0000_0101);
    chk("mis_req_next", 32'(dmem_req), 32'h0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("mis_err_pulse", 32'(addr_err), 32'h0);
    @(posedge clock); #1;

    // Back-to-back: the second lw sits in EX/MEM during the stall and is taken after DONE.
    push_exp(32'h400, 32'h1111_1111, 5'd3, 6'h23, 8'h01);
    push_exp(32'h404, 32'h2222_2222, 5'd4, 6'h23, 8'h02);
    valid_in = 1'b1; op_in = 6'h23; alu_in = 32'h400; dest_in = 5'd3; signals_in = 8'h01;
    @(posedge clock); #1;
    alu_in = 32'h404; dest_in = 5'd4; signals_in = 8'h02;
    dmem_rdata = 32'h1111_1111; dmem_ack = 1'b1;
    @(negedge clock);
    chk("b2b_req1", 32'(dmem_req), 32'h1);
    chk("b2b_addr1", dmem_addr, 32'h400);
    @(posedge clock); #1;
    dmem_ack = 1'b0;
    @(negedge clock);
    chk("b2b_done_stall", 32'(stall_out), 32'h1);
    chk("b2b_done_valid", 32'(valid_out), 32'h1);
    @(posedge clock); #1;
    @(negedge clock);
    chk("b2b_idle_stall", 32'(stall_out), 32'h0);
    @(posedge clock); #1;
    valid_in = 1'b0;
    dmem_rdata = 32'h2222_2222; dmem_ack = 1'b1;
    @(negedge clock);
    chk("b2b_req2", 32'(dmem_req), 32'h1);
    chk("b2b_addr2", dmem_addr, 32'h404);
    @(posedge clock); #1;
    dmem_ack = 1'b0;
    @(negedge clock);
    chk("b2b_done2_valid", 32'(valid_out), 32'h1);
    @(posedge clock); #1;

    // Reset mid-WAIT abandons the access; a late ack must not revive it.
    valid_in = 1'b1; op_in = 6'h23; alu_in = 32'h300; dest_in = 5'd7; signals_in = 8'h55;
    @(posedge clock); #1;
    valid_in = 1'b0;
    @(negedge clock);
    chk("rw_req_before", 32'(dmem_req), 32'h1);
    #1 reset = 1'b0;
    #1;
    chk("rw_req_async", 32'(dmem_req), 32'h0);
    chk("rw_stall_async", 32'(stall_out), 32'h0);
    chk("rw_valid_async", 32'(valid_out), 32'h0);
    @(posedge clock); #1;
    reset = 1'b1;
    dmem_rdata = 32'h9999_9999; dmem_ack = 1'b1;
    @(negedge clock);
    chk("rw_late_ack_stall", 32'(stall_out), 32'h0);
    chk("rw_late_ack_valid", 32'(valid_out), 32'h0);
    @(posedge clock); #1;
    dmem_ack = 1'b0;
    @(negedge clock);
    chk("rw_after_ack_stall", 32'(stall_out), 32'h0);
    chk("rw_after_ack_req", 32'(dmem_req), 32'h0);
    @(posedge clock); #1;
    apply(vecs[0], 20);
    apply(vecs[5], 21);

    @(negedge clock);
    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
